adc_trigger_capture: RTL and testbench

- Sits directly downstream of the AD9481 AXI4-Stream receiver, in the same 16-bit sample stream domain.
- Watches one selected 8-bit ADC channel for a level crossing, or accepts a forced trigger.
- Emits one AXI4-Stream frame of FRAME_LEN beats that includes PRE_LEN pre-trigger samples, taken from an internal ring buffer.
- Supports single-shot and continuous re-arm.

---
 rtl/adc_capture_pkg.sv | 24 ++
 rtl/capture_ring_ram.sv | 24 ++
 rtl/adc_trigger_capture.sv | 212 +++++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC trigger/capture block.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ARMED   = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int unsigned CH_A_LSB = 0;
  localparam int unsigned CH_B_LSB = 8;
  localparam int unsigned CH_W     = 8;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  // Pick the 8-bit lane of a {chB, chA} sample.
  function automatic logic [CH_W-1:0] chan_byte(input logic [15:0] d, input logic ch);
    return ch ? d[CH_B_LSB +: CH_W] : d[CH_A_LSB +: CH_W];
  endfunction

endpackage

// File: rtl/capture_ring_ram.sv
// Simple dual-port ring storage: synchronous write, asynchronous (LUTRAM) read.
module capture_ring_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adc_trigger_capture.sv
// Level/forced trigger capture with pre-trigger history from a ring buffer.
// Optional TRIG_TIMESTAMP_EN adds a latched accepted-beat timestamp output.
module adc_trigger_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PRE_LEN   = 128,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic        axis_aclk,
  input  logic        axis_areset,
  input  logic        arm,
  input  logic        abort,
  input  logic        cont_mode,
  input  logic        force_trig,
  input  logic        trig_chan,
  input  logic        trig_edge,
  input  logic [7:0]  trig_level,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [15:0] s_axis_tdata,
  input  logic [1:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic [1:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic        armed,
  output logic        trig_pulse,
  output logic [15:0] frame_count
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0] trig_timestamp
`endif
);

  localparam int unsigned CNT_W = 16;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [CNT_W-1:0]  beat_cnt;
  logic [15:0]       prev_sample;
  logic [15:0]       ring_rdata;
  logic              accept_c;
  logic              trig_hit_c;
  logic              last_beat_c;
  logic [7:0]        cur_lvl_c;
  logic [7:0]        prev_lvl_c;
  logic              unused_ok;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]       ts_cnt;
`endif

  assign unused_ok = ^{s_axis_tkeep, s_axis_tlast};

  // Input backpressure only while the output register cannot take a beat.
  always_comb begin
    s_axis_tready = 1'b1;
    case (state)
      CAPTURE: s_axis_tready = !m_axis_tvalid || m_axis_tready;
      DRAIN:   s_axis_tready = 1'b0;
      default: s_axis_tready = 1'b1;
    endcase
  end

  assign accept_c    = s_axis_tvalid && s_axis_tready;
  assign rd_addr_c   = wr_ptr - ADDR_W'(PRE_LEN);
  assign last_beat_c = (beat_cnt == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    cur_lvl_c  = chan_byte(s_axis_tdata, trig_chan);
    prev_lvl_c = chan_byte(prev_sample, trig_chan);
    if (trig_edge == EDGE_FALLING)
      trig_hit_c = force_trig || ((prev_lvl_c >= trig_level) && (cur_lvl_c < trig_level));
    else
      trig_hit_c = force_trig || ((prev_lvl_c < trig_level) && (cur_lvl_c >= trig_level));
  end

  capture_ring_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(16)
  ) u_ring (
    .clk   (axis_aclk),
    .we    (accept_c),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .raddr (rd_addr_c),
    .rdata (ring_rdata)
  );

  // Every accepted beat lands in the ring regardless of state.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      wr_ptr      <= '0;
      prev_sample <= '0;
`ifdef TRIG_TIMESTAMP_EN
      ts_cnt      <= '0;
`endif
    end else if (accept_c) begin
      wr_ptr      <= wr_ptr + ADDR_W'(1);
      prev_sample <= s_axis_tdata;
`ifdef TRIG_TIMESTAMP_EN
      ts_cnt      <= ts_cnt + 32'd1;
`endif
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      armed         <= 1'b0;
      trig_pulse    <= 1'b0;
      frame_count   <= '0;
`ifdef TRIG_TIMESTAMP_EN
      trig_timestamp <= '0;
`endif
    end else begin
      trig_pulse <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arm && !abort) begin
            state    <= FILL;
            fill_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        FILL: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept_c) begin
            if (fill_cnt == ADDR_W'(PRE_LEN - 1)) begin
              state <= ARMED;
              armed <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + ADDR_W'(1);
            end
          end
        end

        // The trigger beat itself emits output beat 0 from PRE_LEN samples back.
        ARMED: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
          end else if (accept_c && trig_hit_c) begin
            state         <= CAPTURE;
            armed         <= 1'b0;
            trig_pulse    <= 1'b1;
            beat_cnt      <= CNT_W'(1);
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ring_rdata;
            m_axis_tkeep  <= 2'b11;
            m_axis_tlast  <= 1'b0;
`ifdef TRIG_TIMESTAMP_EN
            trig_timestamp <= ts_cnt;
`endif
          end
        end

        CAPTURE: begin
          if (accept_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ring_rdata;
            m_axis_tkeep  <= 2'b11;
            m_axis_tlast  <= last_beat_c;
            beat_cnt      <= beat_cnt + CNT_W'(1);
            if (last_beat_c) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count <= frame_count + 16'd1;
            if (cont_mode) begin
              state <= ARMED;
              armed <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Randomised scoreboard bench for adc_trigger_capture against a sample-history model.
module tb_adc_trigger_capture;

  localparam int ADDR_W = 5;
  localparam int PRE    = 4;
  localparam int FL     = 8;

  localparam int P_IDLE  = 0;
  localparam int P_FILL  = 1;
  localparam int P_ARM   = 2;
  localparam int P_CAP   = 3;
  localparam int P_DRAIN = 4;

  logic        clk = 1'b0;
  logic        axis_areset;
  logic        arm, abort, cont_mode, force_trig, trig_chan, trig_edge;
  logic [7:0]  trig_level;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        busy, armed, trig_pulse;
  logic [15:0] frame_count;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] trig_timestamp;
`endif

  adc_trigger_capture #(.ADDR_W(ADDR_W), .PRE_LEN(PRE), .FRAME_LEN(FL)) dut (
    .axis_aclk     (clk),
    .axis_areset   (axis_areset),
    .arm           (arm),
    .abort         (abort),
    .cont_mode     (cont_mode),
    .force_trig    (force_trig),
    .trig_chan     (trig_chan),
    .trig_edge     (trig_edge),
    .trig_level    (trig_level),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .armed         (armed),
    .trig_pulse    (trig_pulse),
    .frame_count   (frame_count)
`ifdef TRIG_TIMESTAMP_EN
    ,
    .trig_timestamp(trig_timestamp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] hist[$];
  logic [15:0] frame_buf[FL];
  int          mon_idx;

  int          checks = 0;
  int          errors = 0;

  // Model of the block's observable behaviour.
  int          ph;
  int          fill_n, cap_n;
  int          frames;
  logic        ovalid;
  logic        exp_trig;
  logic [31:0] exp_ts;
  logic        last_acc;
  logic [15:0] m_prev;

  // Stimulus controls.
  logic        bp_en, vld_rand;
  int          data_mode;
  logic [7:0]  ramp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit crosses(input logic [15:0] p, input logic [15:0] c);
    int pv, cv, lv;
    pv = trig_chan ? int'(p) / 256 : int'(p) % 256;
    cv = trig_chan ? int'(c) / 256 : int'(c) % 256;
    lv = int'(trig_level);
    if (trig_edge) return (pv >= lv) && (cv < lv);
    return (pv < lv) && (cv >= lv);
  endfunction

  task automatic new_sample();
    case (data_mode)
      0: begin s_axis_tdata = {8'($urandom), ramp}; ramp = ramp + 8'd1; end
      2: s_axis_tdata = 16'h1010;
      3: s_axis_tdata = {8'hFF, 8'($urandom)};
      4: s_axis_tdata = {8'h00, 8'($urandom)};
      default: s_axis_tdata = 16'($urandom);
    endcase
  endtask

  // One clock: drive inputs, predict the edge, then check the registered outputs.
  task automatic step();
    logic tr_exp, acc, hs, push, plast;
    logic [15:0] pdata;
    int idx;
    if (!(s_axis_tvalid && !last_acc)) begin
      s_axis_tvalid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      new_sample();
    end
    m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    s_axis_tkeep  = 2'($urandom);
    s_axis_tlast  = 1'($urandom);
    #1;
    tr_exp = (ph == P_CAP) ? (!ovalid || m_axis_tready) : (ph == P_DRAIN) ? 1'b0 : 1'b1;
    chk("s_tready", 32'(s_axis_tready), 32'(tr_exp));
    acc      = s_axis_tvalid && tr_exp;
    hs       = ovalid && m_axis_tready;
    push     = 1'b0;
    plast    = 1'b0;
    pdata    = '0;
    exp_trig = 1'b0;
    idx      = hist.size();
    case (ph)
      P_IDLE: if (arm && !abort) begin ph = P_FILL; fill_n = 0; end
      P_FILL: begin
        if (abort) ph = P_IDLE;
        else if (acc) begin
          fill_n++;
          if (fill_n == PRE) ph = P_ARM;
        end
      end
      P_ARM: begin
        if (abort) ph = P_IDLE;
        else if (acc && (force_trig || crosses(m_prev, s_axis_tdata))) begin
          exp_trig = 1'b1;
          exp_ts   = 32'(idx);
          push     = 1'b1;
          pdata    = hist[idx - PRE];
          cap_n    = 1;
          ph       = P_CAP;
        end
      end
      P_CAP: begin
        if (acc) begin
          push  = 1'b1;
          pdata = hist[idx - PRE];
          plast = (cap_n == FL - 1);
          cap_n++;
          if (cap_n == FL) ph = P_DRAIN;
        end
      end
      default: begin
        if (hs) begin
          frames = (frames + 1) % 65536;
          ph = cont_mode ? P_ARM : P_IDLE;
        end
      end
    endcase
    if (push) sb.push_back('{d: pdata, last: plast});
    ovalid = push ? 1'b1 : (hs ? 1'b0 : ovalid);
    if (acc) begin
      hist.push_back(s_axis_tdata);
      m_prev = s_axis_tdata;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(ph != P_IDLE));
    chk("armed", 32'(armed), 32'(ph == P_ARM));
    chk("trig_pulse", 32'(trig_pulse), 32'(exp_trig));
    chk("frame_count", 32'(frame_count), 32'(frames));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(ovalid));
`ifdef TRIG_TIMESTAMP_EN
    chk("trig_timestamp", trig_timestamp, exp_ts);
`endif
  endtask

  task automatic do_reset(input int cycles);
    axis_areset = 1'b1;
    arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_trig_pulse", 32'(trig_pulse), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
`ifdef TRIG_TIMESTAMP_EN
    chk("rst_trig_timestamp", trig_timestamp, 32'd0);
`endif
    ph = P_IDLE; fill_n = 0; cap_n = 0; frames = 0;
    ovalid = 1'b0; exp_trig = 1'b0; exp_ts = '0; m_prev = '0; last_acc = 1'b1;
    hist.delete();
    sb.delete();
    mon_idx = 0;
    repeat (cycles) @(posedge clk);
    #1;
    axis_areset = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (ph != P_IDLE && n < budget);
    if (ph != P_IDLE) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=busy required=idle after %0d cycles", nm, budget);
    end
  endtask

  // Scoreboard monitor: pops on each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!axis_areset && m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h required=no beat", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(m_axis_tdata), 32'(e.d));
          chk("out_last", 32'(m_axis_tlast), 32'(e.last));
          chk("out_keep", 32'(m_axis_tkeep), 32'd3);
        end
        if (mon_idx < FL) frame_buf[mon_idx] = m_axis_tdata;
        mon_idx = m_axis_tlast ? 0 : mon_idx + 1;
      end
    end
  end

  initial begin
    int f0;
    axis_areset = 1'b0;
    arm = 0; abort = 0; cont_mode = 0; force_trig = 0;
    trig_chan = 0; trig_edge = 0; trig_level = 8'd100;
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
    m_axis_tready = 1; bp_en = 0; vld_rand = 0; data_mode = 0; ramp = '0;
    #2;
    do_reset(3);
    step();
    chk("rst_release_tready", 32'(s_axis_tready), 32'd1);

    // Rising crossing on chA ramp.
    ramp = 8'd0; data_mode = 0; trig_level = 8'd100;
    pulse_arm();
    wait_idle(300, "rise");
    chk("rise_first", 32'(frame_buf[0][7:0]), 32'd96);
    chk("rise_last", 32'(frame_buf[FL-1][7:0]), 32'd103);
    chk("rise_frames", 32'(frame_count), 32'd1);

    // Same under random output backpressure.
    bp_en = 1; ramp = 8'd0;
    pulse_arm();
    wait_idle(600, "rise_bp");
    chk("bp_first", 32'(frame_buf[0][7:0]), 32'd96);
    chk("bp_last", 32'(frame_buf[FL-1][7:0]), 32'd103);
    bp_en = 0;

    // Falling crossing on chB.
    trig_chan = 1; trig_edge = 1; trig_level = 8'h80; data_mode = 3;
    pulse_arm();
    repeat (8) step();
    data_mode = 4;
    wait_idle(100, "fall");
    chk("fall_trig_chB", 32'(frame_buf[PRE][15:8]), 32'h00);
    chk("fall_pre_chB", 32'(frame_buf[PRE-1][15:8]), 32'hFF);

    // Forced trigger on flat input.
    data_mode = 2; trig_chan = 0; trig_edge = 0;
    pulse_arm();
    repeat (8) step();
    force_trig = 1;
    step();
    force_trig = 0;
    wait_idle(100, "force");
    for (int i = 0; i < FL; i++) chk("force_flat", 32'(frame_buf[i]), 32'h1010);

    // Continuous re-arm over two crossings, then abort from ARMED.
    cont_mode = 1; data_mode = 0; ramp = 8'd0; trig_level = 8'd100;
    f0 = frames;
    pulse_arm();
    for (int n = 0; n < 800 && frames < f0 + 2; n++) step();
    chk("cont_frames", 32'(frame_count), 32'(f0 + 2));
    chk("cont_armed", 32'(armed), 32'd1);
    cont_mode = 0;
    abort = 1;
    step();
    abort = 0;
    chk("cont_abort_busy", 32'(busy), 32'd0);

    // Abort in ARMED without any crossing.
    ramp = 8'd150;
    pulse_arm();
    repeat (PRE + 2) step();
    chk("abort_armed_pre", 32'(armed), 32'd1);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (4) step();
    chk("abort_no_out", 32'(m_axis_tvalid), 32'd0);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);

    // arm together with abort keeps IDLE.
    arm = 1; abort = 1;
    step();
    arm = 0; abort = 0;
    chk("arm_abort_idle", 32'(busy), 32'd0);
    step();

    // Random rounds: random data, valid, backpressure and trigger setup.
    vld_rand = 1; bp_en = 1; data_mode = 1;
    for (int r = 0; r < 12; r++) begin
      trig_chan  = 1'($urandom);
      trig_edge  = 1'($urandom);
      trig_level = 8'($urandom);
      pulse_arm();
      repeat (30) step();
      force_trig = 1;
      wait_idle(500, "random");
      force_trig = 0;
      repeat (3) step();
    end
    vld_rand = 0; bp_en = 0;

    // Reset while in CAPTURE truncates the frame.
    force_trig = 1;
    pulse_arm();
    repeat (PRE + 3) step();
    force_trig = 0;
    chk("midcap_busy", 32'(busy), 32'd1);
    do_reset(2);
    step();
    chk("midcap_after_tready", 32'(s_axis_tready), 32'd1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
